// File: rtl/chunked_serial_adder_pkg.sv
// Shared FSM encoding and elaboration-time helpers for the chunked serial adder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package chunked_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

    // Ceiling log2 with a floor of 1, so a single-chunk build still has a 1-bit index.
    function automatic int csa_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Request/result bundle between a requester and the chunked serial adder.
// Latency: none (wires only).
// Backpressure: none; busy tells the requester that start is being ignored.
interface chunked_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             V;

    modport master (
        output start, sub, X, Y, Cin,
        input  busy, done, S, Cout, V
    );

    modport slave (
        input  start, sub, X, Y, Cin,
        output busy, done, S, Cout, V
    );

endinterface

// File: rtl/chunked_serial_adder_chunk_adder.sv
// CHUNK-bit combinational ripple-carry adder; also exposes the carry into its top bit.
// Latency: combinational.
// Backpressure: none.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// WIDTH-bit add/subtract computed CHUNK bits per cycle, LS chunk first, carry registered.
// Latency: done pulses WIDTH/CHUNK cycles after start is accepted.
// Backpressure: start is ignored while busy; a start seen during done is taken at once.
module chunked_serial_adder
    import chunked_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chunked_serial_adder_if.slave bus
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = csa_clog2(NCH);

    csa_state_e       state_q, state_d;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] xr, yr, s_q;
    logic             carry, cout_q, v_q;

    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             co, c_msb;
    logic             last, accept;

    assign a_chunk = xr[idx*CHUNK +: CHUNK];
    assign b_chunk = yr[idx*CHUNK +: CHUNK];
    assign last    = (idx == IW'(NCH - 1));
    assign accept  = bus.start && (state_q == IDLE || state_q == DONE);

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a     (a_chunk),
        .b     (b_chunk),
        .ci    (carry),
        .s     (sum_chunk),
        .co    (co),
        .c_msb (c_msb)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx     <= '0;
            xr      <= '0;
            yr      <= '0;
            carry   <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Subtract is X + ~Y + 1: invert Y once here and seed the carry with 1.
                xr    <= bus.X;
                yr    <= bus.sub ? ~bus.Y : bus.Y;
                carry <= bus.sub | bus.Cin;
                idx   <= '0;
            end else if (state_q == RUN) begin
                s_q[idx*CHUNK +: CHUNK] <= sum_chunk;
                carry <= co;
                idx   <= last ? '0 : idx + 1'b1;
                if (last) begin
                    cout_q <= co;
                    v_q    <= co ^ c_msb;
                end
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
    assign bus.V    = v_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench: 16/4 main instance plus 8/8 and 8/1 parameter variants.
module tb_chunked_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    chunked_serial_adder_if #(.WIDTH(16)) b16 ();
    chunked_serial_adder_if #(.WIDTH(8))  b8w ();
    chunked_serial_adder_if #(.WIDTH(8))  b8n ();

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    chunked_serial_adder #(.WIDTH(8),  .CHUNK(8)) dut8w (.clk(clk), .rst_n(rst_n), .bus(b8w));
    chunked_serial_adder #(.WIDTH(8),  .CHUNK(1)) dut8n (.clk(clk), .rst_n(rst_n), .bus(b8n));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full 16-bit operation: latency, busy length, results, single-cycle done.
    task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic cin,
                        input logic sb, input logic [15:0] es, input logic ec,
                        input logic ev, input string tag);
        int n;
        int bc;
        b16.X = x; b16.Y = y; b16.Cin = cin; b16.sub = sb; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        n  = 0;
        bc = (b16.busy === 1'b1) ? 1 : 0;
        while (b16.done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (b16.busy === 1'b1) bc++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_busy_cycles"}, bc, 4);
        check({tag, "_S"}, {16'h0, b16.S}, {16'h0, es});
        check({tag, "_Cout"}, {31'h0, b16.Cout}, {31'h0, ec});
        check({tag, "_V"}, {31'h0, b16.V}, {31'h0, ev});
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'h0, b16.done}, 32'h0);
    endtask

    initial begin
        int n;
        int lw;
        int ln;
        int seen;
        b16.start = 1'b0; b16.sub = 1'b0; b16.X = '0; b16.Y = '0; b16.Cin = 1'b0;
        b8w.start = 1'b0; b8w.sub = 1'b0; b8w.X = '0; b8w.Y = '0; b8w.Cin = 1'b0;
        b8n.start = 1'b0; b8n.sub = 1'b0; b8n.X = '0; b8n.Y = '0; b8n.Cin = 1'b0;

        #12;
        check("rst_busy", {31'h0, b16.busy}, 32'h0);
        check("rst_done", {31'h0, b16.done}, 32'h0);
        check("rst_S",    {16'h0, b16.S},    32'h0);
        check("rst_Cout", {31'h0, b16.Cout}, 32'h0);
        check("rst_V",    {31'h0, b16.V},    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op16(16'h000F, 16'h000D, 1'b1, 1'b0, 16'h001D, 1'b0, 1'b0, "add");
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple_wrap");
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ripple_ovf");
        op16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        op16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");

        // Reset in the cycle where chunk 2 would be written.
        b16.X = 16'h0F0F; b16.Y = 16'h0101; b16.Cin = 1'b0; b16.sub = 1'b0; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'h0, b16.busy}, 32'h0);
        check("midrst_done", {31'h0, b16.done}, 32'h0);
        check("midrst_S",    {16'h0, b16.S},    32'h0);
        check("midrst_Cout", {31'h0, b16.Cout}, 32'h0);
        check("midrst_V",    {31'h0, b16.V},    32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (b16.done === 1'b1) seen = 1;
        end
        check("midrst_no_done", seen, 0);
        op16(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, "after_rst");

        // Second start mid-RUN with different operands must be ignored.
        b16.X = 16'h1234; b16.Y = 16'h4321; b16.Cin = 1'b0; b16.sub = 1'b0; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        @(posedge clk); #1;
        b16.X = 16'hAAAA; b16.Y = 16'h1111; b16.Cin = 1'b1; b16.sub = 1'b1; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        n = 2;
        while (b16.done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("ignore_latency", n, 4);
        check("ignore_S", {16'h0, b16.S}, 32'h5555);
        check("ignore_Cout", {31'h0, b16.Cout}, 32'h0);
        @(posedge clk); #1;
        check("ignore_no_second", {31'h0, b16.busy}, 32'h0);

        // start held high through DONE: the second operation follows with no idle cycle.
        b16.X = 16'h0100; b16.Y = 16'h0200; b16.Cin = 1'b0; b16.sub = 1'b0; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.X = 16'h00FF; b16.Y = 16'h0001; b16.Cin = 1'b1;
        n = 0;
        while (b16.done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_first_latency", n, 4);
        check("b2b_first_S", {16'h0, b16.S}, 32'h0300);
        @(posedge clk); #1;
        b16.start = 1'b0;
        check("b2b_rerun_busy", {31'h0, b16.busy}, 32'h1);
        n = 1;
        while (b16.done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_gap", n, 5);
        check("b2b_second_S", {16'h0, b16.S}, 32'h0101);

        // Parameter variants: single-chunk and bit-serial 8-bit adds of 0xF0 + 0x20.
        b8w.X = 8'hF0; b8w.Y = 8'h20; b8w.start = 1'b1;
        b8n.X = 8'hF0; b8n.Y = 8'h20; b8n.start = 1'b1;
        @(posedge clk); #1;
        b8w.start = 1'b0;
        b8n.start = 1'b0;
        lw = -1;
        ln = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (b8w.done === 1'b1 && lw < 0) lw = i;
            if (b8n.done === 1'b1 && ln < 0) ln = i;
        end
        check("w8c8_latency", lw, 1);
        check("w8c8_S",    {24'h0, b8w.S},    32'h10);
        check("w8c8_Cout", {31'h0, b8w.Cout}, 32'h1);
        check("w8c8_V",    {31'h0, b8w.V},    32'h0);
        check("w8c1_latency", ln, 8);
        check("w8c1_S",    {24'h0, b8n.S},    32'h10);
        check("w8c1_Cout", {31'h0, b8n.Cout}, 32'h1);
        check("w8c1_V",    {31'h0, b8n.V},    32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
